// File: rtl/idli_pkg.sv
// Shared types for the idli nibble-serial execution stage.
// Holds the op encoding and the nibble data type used by every beat.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND,
        OR,
        XOR,
        CMP_EQ,
        CMP_LTU,
        CMP_LTS
    } exs_op_t;

    function automatic logic is_cmp(input exs_op_t op);
        return (op == CMP_EQ) || (op == CMP_LTU) || (op == CMP_LTS);
    endfunction

    // SUB and every compare run lhs + ~rhs + cin
    function automatic logic op_inverts(input exs_op_t op);
        return (op == SUB) || is_cmp(op);
    endfunction

endpackage

// File: rtl/idli_exs_alu_m.sv
// Combinational one-nibble ALU: result, carry out of bit 3 and carry into bit 3.
// Logic ops produce no carries.
module idli_exs_alu_m
    import idli_pkg::*;
(
    input  exs_op_t   op,
    input  sqi_data_t lhs,
    input  sqi_data_t rhs,
    input  logic      cin,
    output sqi_data_t out,
    output logic      cout,
    output logic      c3
);

    sqi_data_t  rhs_eff;
    logic [4:0] sum;
    logic [3:0] low;

    always_comb begin
        rhs_eff = op_inverts(op) ? ~rhs : rhs;
        sum     = {1'b0, lhs} + {1'b0, rhs_eff} + {4'b0, cin};
        low     = {1'b0, lhs[2:0]} + {1'b0, rhs_eff[2:0]} + {3'b0, cin};
        out     = sum[3:0];
        cout    = sum[4];
        c3      = low[3];
        case (op)
            AND: begin out = lhs & rhs; cout = 1'b0; c3 = 1'b0; end
            OR:  begin out = lhs | rhs; cout = 1'b0; c3 = 1'b0; end
            XOR: begin out = lhs ^ rhs; cout = 1'b0; c3 = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/idli_exs_m.sv
// Nibble-serial execute stage: one op takes DATA_W/4 beats, LSB nibble first.
// Results are zero-latency per beat; stall freezes the beat, flush kills the op.
module idli_exs_m
    import idli_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                              i_exs_gck,
    input  logic                              i_exs_rst_n,
    input  exs_op_t                           i_exs_op,
    input  logic                              i_exs_op_vld,
    output logic                              o_exs_op_acp,
    input  sqi_data_t                         i_exs_lhs,
    input  sqi_data_t                         i_exs_rhs,
    input  logic                              i_exs_stall,
    input  logic                              i_exs_flush,
    output sqi_data_t                         o_exs_out,
    output logic                              o_exs_out_vld,
    output logic [$clog2(DATA_W/4)-1:0]       o_exs_ctr,
    output logic                              o_exs_pred,
    output logic                              o_exs_pred_vld,
    output logic                              o_exs_done
);

    localparam int BEATS = DATA_W / 4;
    localparam int CTR_W = $clog2(BEATS);

    exs_op_t          op_q;
    logic             op_vld_q;
    logic [CTR_W-1:0] ctr_q;
    logic             carry_q;
    logic             eq_q;

    logic first, last, fire, cin, cout, c3, eq_acc;

    assign first = (ctr_q == '0);
    assign last  = (ctr_q == CTR_W'(BEATS - 1));
    assign fire  = op_vld_q && !i_exs_stall && !i_exs_flush;
    assign cin   = first ? op_inverts(op_q) : carry_q;

    idli_exs_alu_m u_alu (
        .op   (op_q),
        .lhs  (i_exs_lhs),
        .rhs  (i_exs_rhs),
        .cin  (cin),
        .out  (o_exs_out),
        .cout (cout),
        .c3   (c3)
    );

    // Beat 0 restarts the equality accumulator regardless of its old value
    assign eq_acc = (first || eq_q) && (i_exs_lhs == i_exs_rhs);

    always_comb begin
        o_exs_pred = 1'b0;
        case (op_q)
            CMP_EQ:  o_exs_pred = eq_acc;
            CMP_LTU: o_exs_pred = !cout;
            CMP_LTS: o_exs_pred = o_exs_out[3] ^ (c3 ^ cout);
            default: ;
        endcase
    end

    assign o_exs_op_acp   = (!op_vld_q || (last && !i_exs_stall)) && !i_exs_flush;
    assign o_exs_out_vld  = fire;
    assign o_exs_done     = fire && last;
    assign o_exs_pred_vld = fire && last && is_cmp(op_q);
    assign o_exs_ctr      = ctr_q;

    always_ff @(posedge i_exs_gck or negedge i_exs_rst_n) begin
        if (!i_exs_rst_n) begin
            op_vld_q <= 1'b0;
            ctr_q    <= '0;
        end else if (o_exs_op_acp) begin
            op_vld_q <= i_exs_op_vld;
            ctr_q    <= '0;
        end else if (i_exs_flush) begin
            op_vld_q <= 1'b0;
            ctr_q    <= '0;
        end else if (op_vld_q && !i_exs_stall) begin
            ctr_q    <= ctr_q + CTR_W'(1);
        end
    end

    always_ff @(posedge i_exs_gck) begin
        if (o_exs_op_acp) begin
            op_q <= i_exs_op;
        end
        if (fire) begin
            carry_q <= cout;
            eq_q    <= eq_acc;
        end
    end

endmodule

// File: tb/tb_idli_exs_m.sv
// Directed bench for idli_exs_m: 16-bit instance for function, 32-bit instance for mid-op reset.
module tb_idli_exs_m;
    import idli_pkg::*;

    logic      clk;
    logic      rst_n, rst32_n;
    exs_op_t   op;
    logic      op_vld, stall, flush;
    sqi_data_t lhs, rhs;

    logic      acp, out_vld, pred, pred_vld, done;
    sqi_data_t out;
    logic [1:0] ctr;

    logic      acp32, out_vld32, pred32, pred_vld32, done32;
    sqi_data_t out32;
    logic [2:0] ctr32;

    int passed = 0;
    int total  = 0;

    idli_exs_m #(.DATA_W(16)) dut (
        .i_exs_gck(clk), .i_exs_rst_n(rst_n), .i_exs_op(op), .i_exs_op_vld(op_vld),
        .o_exs_op_acp(acp), .i_exs_lhs(lhs), .i_exs_rhs(rhs), .i_exs_stall(stall),
        .i_exs_flush(flush), .o_exs_out(out), .o_exs_out_vld(out_vld), .o_exs_ctr(ctr),
        .o_exs_pred(pred), .o_exs_pred_vld(pred_vld), .o_exs_done(done)
    );

    idli_exs_m #(.DATA_W(32)) dut32 (
        .i_exs_gck(clk), .i_exs_rst_n(rst32_n), .i_exs_op(op), .i_exs_op_vld(op_vld),
        .o_exs_op_acp(acp32), .i_exs_lhs(lhs), .i_exs_rhs(rhs), .i_exs_stall(stall),
        .i_exs_flush(flush), .o_exs_out(out32), .o_exs_out_vld(out_vld32), .o_exs_ctr(ctr32),
        .o_exs_pred(pred32), .o_exs_pred_vld(pred_vld32), .o_exs_done(done32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input int k);
        lhs = a[4*k +: 4];
        rhs = b[4*k +: 4];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst32_n = 1'b0;
        op = ADD; op_vld = 1'b0; stall = 1'b0; flush = 1'b0; lhs = '0; rhs = '0;
        @(negedge clk);
        total++; if (acp !== 1'b1) $display("FAIL reset_acp got %b want 1", acp); else passed++;
        total++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld got %b want 0", out_vld); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (pred_vld !== 1'b0) $display("FAIL reset_pred_vld got %b want 0", pred_vld); else passed++;
        total++; if (ctr !== 2'd0) $display("FAIL reset_ctr got %0d want 0", ctr); else passed++;
        total++; if (acp32 !== 1'b1 || ctr32 !== 3'd0) $display("FAIL reset32 acp=%b ctr=%0d want 1,0", acp32, ctr32); else passed++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [15:0] exp_v;
        exp_v = 16'h0100;
        op = ADD; op_vld = 1'b1;
        @(negedge clk);
        total++; if (acp !== 1'b1) $display("FAIL add_acp got %b want 1", acp); else passed++;
        step();
        op_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_beat(32'h00FF, 32'h0001, k);
            @(negedge clk);
            total++; if (out !== exp_v[4*k +: 4] || out_vld !== 1'b1)
                $display("FAIL add_out beat %0d got %h/%b want %h/1", k, out, out_vld, exp_v[4*k +: 4]); else passed++;
            total++; if (ctr !== 2'(k) || done !== (k == 3))
                $display("FAIL add_ctr_done beat %0d got ctr=%0d done=%b want %0d/%b", k, ctr, done, k, (k == 3)); else passed++;
            step();
        end
        @(negedge clk);
        total++; if (out_vld !== 1'b0 || acp !== 1'b1)
            $display("FAIL add_idle got out_vld=%b acp=%b want 0/1", out_vld, acp); else passed++;
        step();
    endtask

    task automatic test_cmp(input exs_op_t c_op, input logic [15:0] a, input logic [15:0] b, input logic exp_pred);
        op = c_op; op_vld = 1'b1;
        step();
        op_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_beat({16'h0, a}, {16'h0, b}, k);
            @(negedge clk);
            total++; if (pred_vld !== (k == 3))
                $display("FAIL cmp_pred_vld op=%0d beat %0d got %b want %b", c_op, k, pred_vld, (k == 3)); else passed++;
            if (k == 3) begin
                total++; if (pred !== exp_pred)
                    $display("FAIL cmp_pred op=%0d got %b want %b", c_op, pred, exp_pred); else passed++;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exs_op_t     ops   [4] = '{SUB, CMP_EQ, CMP_EQ, CMP_EQ};
        logic [15:0] av    [4] = '{16'h0005, 16'h1234, 16'h1334, 16'h1234};
        logic [15:0] bv    [4] = '{16'h0003, 16'h1234, 16'h1234, 16'h1234};
        logic [15:0] ev    [4] = '{16'h0002, 16'h0000, 16'h0100, 16'h0000};
        logic        pv    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] e;
        op = ops[0]; op_vld = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                e = ev[i];
                set_beat({16'h0, av[i]}, {16'h0, bv[i]}, k);
                if (k == 3 && i < 3) begin op = ops[i+1]; op_vld = 1'b1; end
                else op_vld = 1'b0;
                @(negedge clk);
                total++; if (out !== e[4*k +: 4] || ctr !== 2'(k) || out_vld !== 1'b1)
                    $display("FAIL b2b_beat op%0d beat %0d got out=%h ctr=%0d vld=%b want %h/%0d/1",
                             i, k, out, ctr, out_vld, e[4*k +: 4], k); else passed++;
                if (k == 3) begin
                    total++; if (acp !== 1'b1) $display("FAIL b2b_acp op%0d got %b want 1", i, acp); else passed++;
                    total++; if (pred_vld !== (i != 0) || (i != 0 && pred !== pv[i]))
                        $display("FAIL b2b_pred op%0d got vld=%b pred=%b want %b/%b", i, pred_vld, pred, (i != 0), pv[i]); else passed++;
                end
                step();
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp_v;
        int nst;
        exp_v = 16'h1000;
        op = ADD; op_vld = 1'b1;
        step();
        op_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_beat(32'h0FFF, 32'h0001, k);
            nst = (k == 2) ? 2 : (k == 3) ? 1 : 0;
            for (int s = 0; s < nst; s++) begin
                stall = 1'b1;
                @(negedge clk);
                total++; if (ctr !== 2'(k) || out_vld !== 1'b0 || done !== 1'b0 || acp !== 1'b0)
                    $display("FAIL stall_hold beat %0d got ctr=%0d vld=%b done=%b acp=%b want %0d/0/0/0",
                             k, ctr, out_vld, done, acp, k); else passed++;
                step();
            end
            stall = 1'b0;
            @(negedge clk);
            total++; if (out !== exp_v[4*k +: 4] || out_vld !== 1'b1 || done !== (k == 3))
                $display("FAIL stall_out beat %0d got %h/%b/%b want %h/1/%b",
                         k, out, out_vld, done, exp_v[4*k +: 4], (k == 3)); else passed++;
            step();
        end
    endtask

    task automatic test_flush();
        op = ADD; op_vld = 1'b1;
        step();
        op_vld = 1'b0;
        set_beat(32'h1111, 32'h2222, 0);
        step();
        set_beat(32'h1111, 32'h2222, 1);
        flush = 1'b1; op = SUB; op_vld = 1'b1;
        @(negedge clk);
        total++; if (acp !== 1'b0 || out_vld !== 1'b0 || done !== 1'b0)
            $display("FAIL flush_cycle got acp=%b vld=%b done=%b want 0/0/0", acp, out_vld, done); else passed++;
        step();
        flush = 1'b0; op_vld = 1'b0;
        @(negedge clk);
        total++; if (out_vld !== 1'b0 || ctr !== 2'd0 || acp !== 1'b1)
            $display("FAIL flush_after got vld=%b ctr=%0d acp=%b want 0/0/1", out_vld, ctr, acp); else passed++;
        op = CMP_LTU; op_vld = 1'b1;
        step();
        op_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_beat(32'h0000, 32'h0001, k);
            step();
        end
        set_beat(32'h0000, 32'h0001, 3);
        flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0 || pred_vld !== 1'b0 || acp !== 1'b0)
            $display("FAIL flush_last got done=%b pred_vld=%b acp=%b want 0/0/0", done, pred_vld, acp); else passed++;
        step();
        flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        total++; if (out_vld !== 1'b0 || ctr !== 2'd0)
            $display("FAIL flush_last_after got vld=%b ctr=%0d want 0/0", out_vld, ctr); else passed++;
        step();
    endtask

    task automatic test_reset32();
        rst32_n = 1'b1;
        step();
        op = ADD; op_vld = 1'b1;
        step();
        op_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_beat(32'h0000_0001, 32'h0, k);
            step();
        end
        set_beat(32'h0000_0001, 32'h0, 5);
        @(negedge clk);
        total++; if (ctr32 !== 3'd5 || out_vld32 !== 1'b1)
            $display("FAIL r32_beat5 got ctr=%0d vld=%b want 5/1", ctr32, out_vld32); else passed++;
        #1 rst32_n = 1'b0;
        #1;
        total++; if (ctr32 !== 3'd0 || acp32 !== 1'b1 || done32 !== 1'b0 || out_vld32 !== 1'b0)
            $display("FAIL r32_reset got ctr=%0d acp=%b done=%b vld=%b want 0/1/0/0",
                     ctr32, acp32, done32, out_vld32); else passed++;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            total++; if (done32 !== 1'b0 || pred_vld32 !== 1'b0)
                $display("FAIL r32_hold cycle %0d got done=%b pred_vld=%b want 0/0", c, done32, pred_vld32); else passed++;
        end
        step();
        rst32_n = 1'b1;
        @(negedge clk);
        total++; if (ctr32 !== 3'd0 || out_vld32 !== 1'b0 || acp32 !== 1'b1)
            $display("FAIL r32_release got ctr=%0d vld=%b acp=%b want 0/0/1", ctr32, out_vld32, acp32); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp(CMP_LTS, 16'h8000, 16'h0001, 1'b1);
        test_cmp(CMP_LTU, 16'h8000, 16'h0001, 1'b0);
        test_cmp(CMP_LTS, 16'h0001, 16'h8000, 1'b0);
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset32();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
